// File: rtl/alu_pkg.sv
// Shared encodings for the MIPS datapath ALU: opcodes, datapath width and shift-amount width.
package alu_pkg;
   localparam int WIDTH   = 32;
   localparam int SHAMT_W = 5;

   localparam logic [3:0] ALU_ADD  = 4'b0000;
   localparam logic [3:0] ALU_SUB  = 4'b0001;
   localparam logic [3:0] ALU_MUL  = 4'b0010;
   localparam logic [3:0] ALU_AND  = 4'b0011;
   localparam logic [3:0] ALU_XOR  = 4'b0100;
   localparam logic [3:0] ALU_OR   = 4'b0101;
   localparam logic [3:0] ALU_NOT  = 4'b0110;
   localparam logic [3:0] ALU_NEG  = 4'b0111;
   localparam logic [3:0] ALU_SLL  = 4'b1000;
   localparam logic [3:0] ALU_SRL  = 4'b1001;
   localparam logic [3:0] ALU_SLA  = 4'b1010;
   localparam logic [3:0] ALU_SRA  = 4'b1011;
   localparam logic [3:0] ALU_ROL  = 4'b1100;
   localparam logic [3:0] ALU_ROR  = 4'b1101;
   localparam logic [3:0] ALU_SLT  = 4'b1110;
   localparam logic [3:0] ALU_SLTU = 4'b1111;

   // Shift-kind select is the low three opcode bits of the 1xxx shift/rotate group.
   localparam logic [2:0] SH_SLL = 3'b000;
   localparam logic [2:0] SH_SRL = 3'b001;
   localparam logic [2:0] SH_SLA = 3'b010;
   localparam logic [2:0] SH_SRA = 3'b011;
   localparam logic [2:0] SH_ROL = 3'b100;
   localparam logic [2:0] SH_ROR = 3'b101;
endpackage

// File: rtl/alu_shifter.sv
// Combinational shifter/rotator for the ALU shift group; amount is already truncated to SHAMT_W bits.
module alu_shifter
   import alu_pkg::*;
(
   input  logic [WIDTH-1:0]   a,
   input  logic [SHAMT_W-1:0] amount,
   input  logic [2:0]         kind,
   output logic [WIDTH-1:0]   result
);

   logic signed [WIDTH-1:0] a_s;
   logic [2*WIDTH-1:0]      rol_w;
   logic [2*WIDTH-1:0]      ror_w;

   // Rotates shift a doubled copy of A so wrap-around bits fall in naturally, including amount 0.
   always_comb begin
      a_s   = $signed(a);
      rol_w = {a, a} << amount;
      ror_w = {a, a} >> amount;
      result = '0;
      case (kind)
         SH_SLL, SH_SLA: result = a << amount;
         SH_SRL:         result = a >> amount;
         SH_SRA:         result = a_s >>> amount;
         SH_ROL:         result = rol_w[2*WIDTH-1:WIDTH];
         SH_ROR:         result = ror_w[WIDTH-1:0];
         default:        result = '0;
      endcase
   end

endmodule

// File: rtl/alu.sv
// 32-bit single-cycle MIPS ALU: combinational result and Zero flag plus a registered copy of the result.
module alu
   import alu_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic [WIDTH-1:0]   A,
   input  logic [WIDTH-1:0]   B,
   input  logic [3:0]         ALUControl,
   output logic [WIDTH-1:0]   ALUResult,
   output logic               Zero,
   output logic [WIDTH-1:0]   ResultReg
);

   logic [WIDTH-1:0]        shift_res;
   logic signed [WIDTH-1:0] a_s;
   logic signed [WIDTH-1:0] b_s;
   logic                    lt_signed;
   logic                    lt_unsigned;
   logic [WIDTH-1:0]        alu_result;
   logic [WIDTH-1:0]        result_reg_d;
   logic [WIDTH-1:0]        result_reg_q;

   alu_shifter u_shifter (
      .a      (A),
      .amount (B[SHAMT_W-1:0]),
      .kind   (ALUControl[2:0]),
      .result (shift_res)
   );

   always_comb begin
      a_s         = $signed(A);
      b_s         = $signed(B);
      lt_signed   = a_s < b_s;
      lt_unsigned = A < B;
      alu_result  = '0;
      case (ALUControl)
         ALU_ADD:  alu_result = A + B;
         ALU_SUB:  alu_result = A - B;
         ALU_MUL:  alu_result = A * B;
         ALU_AND:  alu_result = A & B;
         ALU_XOR:  alu_result = A ^ B;
         ALU_OR:   alu_result = A | B;
         ALU_NOT:  alu_result = ~A;
         ALU_NEG:  alu_result = '0 - A;
         ALU_SLL, ALU_SRL, ALU_SLA, ALU_SRA, ALU_ROL, ALU_ROR:
                   alu_result = shift_res;
         ALU_SLT:  alu_result = {{(WIDTH-1){1'b0}}, lt_signed};
         ALU_SLTU: alu_result = {{(WIDTH-1){1'b0}}, lt_unsigned};
         default:  alu_result = '0;
      endcase
   end

   always_comb begin
      result_reg_d = rst ? '0 : alu_result;
   end

   always_ff @(posedge clk) begin
      result_reg_q <= result_reg_d;
   end

   assign ALUResult = alu_result;
   assign Zero      = (alu_result == '0);
   assign ResultReg = result_reg_q;

endmodule

// File: tb/tb_alu.sv
// Directed-vector bench for the ALU: combinational ops and flags, then the registered result and reset.
module tb_alu;
   import alu_pkg::*;

   logic              clk;
   logic              rst;
   logic [WIDTH-1:0]  A;
   logic [WIDTH-1:0]  B;
   logic [3:0]        ALUControl;
   logic [WIDTH-1:0]  ALUResult;
   logic              Zero;
   logic [WIDTH-1:0]  ResultReg;

   int total = 0;
   int bad   = 0;

   typedef struct {
      string       tag;
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic        zero;
   } vec_t;

   vec_t vecs[$];

   alu dut (
      .clk        (clk),
      .rst        (rst),
      .A          (A),
      .B          (B),
      .ALUControl (ALUControl),
      .ALUResult  (ALUResult),
      .Zero       (Zero),
      .ResultReg  (ResultReg)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   initial begin
      rst = 1'b1;
      A = '0;
      B = '0;
      ALUControl = ALU_ADD;

      vecs.push_back('{"add_wrap",  ALU_ADD,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1});
      vecs.push_back('{"sub",       ALU_SUB,  32'h00000005, 32'h00000007, 32'hFFFFFFFE, 1'b0});
      vecs.push_back('{"mul_ovf",   ALU_MUL,  32'h00010000, 32'h00010000, 32'h00000000, 1'b1});
      vecs.push_back('{"mul_neg",   ALU_MUL,  32'hFFFFFFFF, 32'h00000003, 32'hFFFFFFFD, 1'b0});
      vecs.push_back('{"and",       ALU_AND,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0});
      vecs.push_back('{"xor",       ALU_XOR,  32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1'b0});
      vecs.push_back('{"or",        ALU_OR,   32'hF0F0F0F0, 32'h0F000F00, 32'hFFF0FFF0, 1'b0});
      vecs.push_back('{"not",       ALU_NOT,  32'h00000000, 32'h12345678, 32'hFFFFFFFF, 1'b0});
      vecs.push_back('{"neg",       ALU_NEG,  32'h00000001, 32'h00000009, 32'hFFFFFFFF, 1'b0});
      vecs.push_back('{"neg_min",   ALU_NEG,  32'h80000000, 32'h00000000, 32'h80000000, 1'b0});
      vecs.push_back('{"sra",       ALU_SRA,  32'h80000000, 32'h00000004, 32'hF8000000, 1'b0});
      vecs.push_back('{"srl",       ALU_SRL,  32'h80000000, 32'h00000004, 32'h08000000, 1'b0});
      vecs.push_back('{"sll_33",    ALU_SLL,  32'h00000001, 32'h00000021, 32'h00000002, 1'b0});
      vecs.push_back('{"sla_33",    ALU_SLA,  32'h00000001, 32'h00000021, 32'h00000002, 1'b0});
      vecs.push_back('{"sra_32",    ALU_SRA,  32'h80000000, 32'h00000020, 32'h80000000, 1'b0});
      vecs.push_back('{"rol",       ALU_ROL,  32'h80000001, 32'h00000001, 32'h00000003, 1'b0});
      vecs.push_back('{"ror",       ALU_ROR,  32'h80000001, 32'h00000001, 32'hC0000000, 1'b0});
      vecs.push_back('{"rol_0",     ALU_ROL,  32'h12345678, 32'h00000000, 32'h12345678, 1'b0});
      vecs.push_back('{"ror_8",     ALU_ROR,  32'h12345678, 32'h00000008, 32'h78123456, 1'b0});
      vecs.push_back('{"slt",       ALU_SLT,  32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0});
      vecs.push_back('{"sltu",      ALU_SLTU, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1});
      vecs.push_back('{"slt_false", ALU_SLT,  32'h00000001, 32'hFFFFFFFF, 32'h00000000, 1'b1});

      // Two reset edges, ResultReg must be cleared.
      @(posedge clk);
      @(posedge clk);
      #1;
      chk("reset_rr", ResultReg, 32'h00000000);

      foreach (vecs[i]) begin
         ALUControl = vecs[i].op;
         A = vecs[i].a;
         B = vecs[i].b;
         #1;
         chk({vecs[i].tag, "_res"}, ALUResult, vecs[i].res);
         chk({vecs[i].tag, "_zero"}, {31'b0, Zero}, {31'b0, vecs[i].zero});
      end

      // Registered path: ADD 2+3 captured one edge later.
      @(negedge clk);
      rst = 1'b0;
      ALUControl = ALU_ADD;
      A = 32'd2;
      B = 32'd3;
      @(posedge clk);
      #1;
      chk("rr_add", ResultReg, 32'h00000005);

      @(negedge clk);
      A = 32'd10;
      B = 32'd20;
      @(posedge clk);
      #1;
      chk("rr_follow", ResultReg, 32'd30);

      // Mid-operation reset clears the register only; the combinational result keeps tracking.
      @(negedge clk);
      A = 32'd2;
      B = 32'd3;
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("rr_midrst", ResultReg, 32'h00000000);
      chk("res_midrst", ALUResult, 32'h00000005);

      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk("rr_after_rst", ResultReg, 32'h00000005);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
